// File: rtl/otter_iobus_responder.sv
// otter_iobus_responder
// Responding end of the OTTER_MCU IOBUS. It decodes IOBUS_ADDR, IOBUS_WR and
// IOBUS_OUT against a fixed register window at BASE_ADDR and returns read
// data combinationally on IOBUS_IN.
//
// Registers (byte offset from BASE_ADDR):
//   +0x00 SW     read-only, synchronised switches (zero-extended)
//   +0x20 LED    read/write LED register
//   +0x40 TCNT   read/write timer counter
//   +0x44 TCMP   read/write timer compare value (0 never matches)
//   +0x48 TCTRL  bit0 EN (r/w), bit1 PEND (read, write-1-to-clear)
//   +0x60 TXD    write pushes IOBUS_OUT[7:0] into the TX FIFO, reads 0
//   +0x64 TXSTAT {count[23:16], OVF[2], FULL[1], EMPTY[0]}, write bit2=1 clears OVF
//
// Ports:
//   CLK, RESET_N              clock, asynchronous active-low reset
//   IOBUS_ADDR/OUT/WR         MCU address, write data, write strobe
//   IOBUS_IN                  read data back to the MCU
//   SWITCHES / LEDS           board switches in, LED register out
//   INTR                      timer interrupt level (equals PEND)
//   TX_DATA/TX_VALID/TX_READY FIFO head byte stream with valid/ready handshake

module otter_iobus_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          SW_WIDTH   = 16,
    parameter int          LED_WIDTH  = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [31:0]          IOBUS_ADDR,
    input  logic [31:0]          IOBUS_OUT,
    input  logic                 IOBUS_WR,
    output logic [31:0]          IOBUS_IN,
    input  logic [SW_WIDTH-1:0]  SWITCHES,
    output logic [LED_WIDTH-1:0] LEDS,
    output logic                 INTR,
    output logic [7:0]           TX_DATA,
    output logic                 TX_VALID,
    input  logic                 TX_READY
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [31:0] ADDR_SW     = BASE_ADDR + 32'h00;
    localparam logic [31:0] ADDR_LED    = BASE_ADDR + 32'h20;
    localparam logic [31:0] ADDR_TCNT   = BASE_ADDR + 32'h40;
    localparam logic [31:0] ADDR_TCMP   = BASE_ADDR + 32'h44;
    localparam logic [31:0] ADDR_TCTRL  = BASE_ADDR + 32'h48;
    localparam logic [31:0] ADDR_TXD    = BASE_ADDR + 32'h60;
    localparam logic [31:0] ADDR_TXSTAT = BASE_ADDR + 32'h64;

    logic [SW_WIDTH-1:0]  sw_meta;
    logic [SW_WIDTH-1:0]  sw_sync;
    logic [LED_WIDTH-1:0] led_reg;
    logic [31:0]          tcnt;
    logic [31:0]          tcmp;
    logic                 tmr_en;
    logic                 tmr_pend;

    logic [7:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     head_ptr;
    logic [PTR_W-1:0]     tail_ptr;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_ovf;

    logic wr_led, wr_tcnt, wr_tcmp, wr_tctrl, wr_txd, wr_txstat;
    logic fifo_full, fifo_empty;
    logic do_pop, do_push, push_dropped;
    logic tmr_match;

    // Write strobes: full 32-bit compare, so aliases of the window are ignored.
    assign wr_led    = IOBUS_WR && (IOBUS_ADDR == ADDR_LED);
    assign wr_tcnt   = IOBUS_WR && (IOBUS_ADDR == ADDR_TCNT);
    assign wr_tcmp   = IOBUS_WR && (IOBUS_ADDR == ADDR_TCMP);
    assign wr_tctrl  = IOBUS_WR && (IOBUS_ADDR == ADDR_TCTRL);
    assign wr_txd    = IOBUS_WR && (IOBUS_ADDR == ADDR_TXD);
    assign wr_txstat = IOBUS_WR && (IOBUS_ADDR == ADDR_TXSTAT);

    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);

    // A pop frees a slot in the same edge, so a push into a full FIFO is
    // still accepted when the head is being consumed.
    assign do_pop       = !fifo_empty && TX_READY;
    assign do_push      = wr_txd && (!fifo_full || do_pop);
    assign push_dropped = wr_txd && fifo_full && !do_pop;

    assign tmr_match = tmr_en && (tcmp != 32'h0) && (tcnt == tcmp);

    assign LEDS     = led_reg;
    assign INTR     = tmr_pend;
    assign TX_VALID = !fifo_empty;
    assign TX_DATA  = fifo_empty ? 8'h00 : fifo_mem[head_ptr];

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SWITCHES;
            sw_sync <= sw_meta;
        end
    end

    // LED register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            led_reg <= '0;
        end else if (wr_led) begin
            led_reg <= IOBUS_OUT[LED_WIDTH-1:0];
        end
    end

    // Timer. A software load of TCNT beats the increment; a new match beats
    // a write-1-to-clear of PEND in the same cycle so no event is lost.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tcnt     <= 32'h0;
            tcmp     <= 32'h0;
            tmr_en   <= 1'b0;
            tmr_pend <= 1'b0;
        end else begin
            if (wr_tcnt) begin
                tcnt <= IOBUS_OUT;
            end else if (tmr_en) begin
                tcnt <= tcnt + 32'h1;
            end
            if (wr_tcmp) begin
                tcmp <= IOBUS_OUT;
            end
            if (wr_tctrl) begin
                tmr_en <= IOBUS_OUT[0];
            end
            if (tmr_match) begin
                tmr_pend <= 1'b1;
            end else if (wr_tctrl && IOBUS_OUT[1]) begin
                tmr_pend <= 1'b0;
            end
        end
    end

    // TX FIFO storage. Cleared on reset so TX_DATA never exposes stale bytes.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= 8'h00;
            end
        end else if (do_push) begin
            fifo_mem[tail_ptr] <= IOBUS_OUT[7:0];
        end
    end

    // TX FIFO pointers, occupancy and sticky overflow. Pointers are PTR_W
    // bits wide, so they wrap modulo FIFO_DEPTH on their own.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            fifo_count <= '0;
            fifo_ovf   <= 1'b0;
        end else begin
            if (do_push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
            if (push_dropped) begin
                fifo_ovf <= 1'b1;
            end else if (wr_txstat && IOBUS_OUT[2]) begin
                fifo_ovf <= 1'b0;
            end
        end
    end

    // Read mux: zero latency, no side effects, unmapped addresses return 0.
    always_comb begin
        IOBUS_IN = 32'h0;
        case (IOBUS_ADDR)
            ADDR_SW:     IOBUS_IN = 32'(sw_sync);
            ADDR_LED:    IOBUS_IN = 32'(led_reg);
            ADDR_TCNT:   IOBUS_IN = tcnt;
            ADDR_TCMP:   IOBUS_IN = tcmp;
            ADDR_TCTRL:  IOBUS_IN = {30'h0, tmr_pend, tmr_en};
            ADDR_TXSTAT: IOBUS_IN = {8'h00, 8'(fifo_count), 13'h0,
                                     fifo_ovf, fifo_full, fifo_empty};
            default:     IOBUS_IN = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_otter_iobus_responder.sv
// tb_otter_iobus_responder
// Directed plus randomized bench for otter_iobus_responder. A behavioural
// model (switch history, plain integers for the timer, a byte queue for the
// TX FIFO) predicts every cycle's outputs; selected steps also carry a fixed
// expected read value.

module tb_otter_iobus_responder;

    localparam logic [31:0] BASE  = 32'h1100_0000;
    localparam int          DEPTH = 8;

    localparam logic [31:0] A_SW     = BASE + 32'h00;
    localparam logic [31:0] A_LED    = BASE + 32'h20;
    localparam logic [31:0] A_TCNT   = BASE + 32'h40;
    localparam logic [31:0] A_TCMP   = BASE + 32'h44;
    localparam logic [31:0] A_TCTRL  = BASE + 32'h48;
    localparam logic [31:0] A_TXD    = BASE + 32'h60;
    localparam logic [31:0] A_TXSTAT = BASE + 32'h64;

    logic        CLK;
    logic        RESET_N;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic [15:0] SWITCHES;
    logic [15:0] LEDS;
    logic        INTR;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;

    int vectors;
    int miscompares;

    // Reference model state
    logic [15:0] m_sw_hist [2];
    logic [15:0] m_led;
    logic [31:0] m_tcnt;
    logic [31:0] m_tcmp;
    logic        m_en;
    logic        m_pend;
    logic [7:0]  m_q [$];
    logic        m_ovf;

    logic [31:0] addr_list [10];

    otter_iobus_responder #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH),
        .SW_WIDTH  (16),
        .LED_WIDTH (16)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IOBUS_ADDR(IOBUS_ADDR),
        .IOBUS_OUT (IOBUS_OUT),
        .IOBUS_WR  (IOBUS_WR),
        .IOBUS_IN  (IOBUS_IN),
        .SWITCHES  (SWITCHES),
        .LEDS      (LEDS),
        .INTR      (INTR),
        .TX_DATA   (TX_DATA),
        .TX_VALID  (TX_VALID),
        .TX_READY  (TX_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic model_reset();
        m_sw_hist[0] = '0;
        m_sw_hist[1] = '0;
        m_led  = '0;
        m_tcnt = '0;
        m_tcmp = '0;
        m_en   = 1'b0;
        m_pend = 1'b0;
        m_q.delete();
        m_ovf  = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int sz;
        sz = m_q.size();
        case (a)
            A_SW:     return {16'h0, m_sw_hist[1]};
            A_LED:    return {16'h0, m_led};
            A_TCNT:   return m_tcnt;
            A_TCMP:   return m_tcmp;
            A_TCTRL:  return {30'h0, m_pend, m_en};
            A_TXSTAT: return {8'h0, 8'(sz), 13'h0, m_ovf, (sz == DEPTH), (sz == 0)};
            default:  return 32'h0;
        endcase
    endfunction

    // One rising edge of the model, computed from the register-map rules.
    task automatic model_edge(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic rdy, input logic [15:0] sw);
        logic       hit;
        logic [7:0] popped;
        logic       did_pop;
        hit = (m_en && m_tcmp != 0 && m_tcnt == m_tcmp);
        m_sw_hist[1] = m_sw_hist[0];
        m_sw_hist[0] = sw;
        did_pop = (m_q.size() > 0) && rdy;
        if (did_pop) popped = m_q.pop_front();
        if (wr && a == A_TXD) begin
            if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end
        if (wr && a == A_TXSTAT && d[2]) m_ovf = 1'b0;
        if (wr && a == A_LED) m_led = d[15:0];
        if (wr && a == A_TCNT) m_tcnt = d;
        else if (m_en) m_tcnt = m_tcnt + 1;
        if (wr && a == A_TCMP) m_tcmp = d;
        if (wr && a == A_TCTRL) begin
            m_en = d[0];
            if (d[1]) m_pend = 1'b0;
        end
        if (hit) m_pend = 1'b1;
    endtask

    task automatic checkOutput(input logic chk_en, input logic [31:0] chk_val);
        logic [7:0] exp_data;
        exp_data = (m_q.size() > 0) ? m_q[0] : 8'h00;
        check32("iobus_in", IOBUS_IN, model_read(IOBUS_ADDR));
        check32("leds", {16'h0, LEDS}, {16'h0, m_led});
        check32("intr", {31'h0, INTR}, {31'h0, m_pend});
        check32("tx_valid", {31'h0, TX_VALID}, {31'h0, (m_q.size() > 0)});
        check32("tx_data", {24'h0, TX_DATA}, {24'h0, exp_data});
        if (chk_en) check32("directed_read", IOBUS_IN, chk_val);
    endtask

    // Drive one bus cycle just after a rising edge, check before the next
    // edge, then advance the model across that edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                 input logic rdy, input logic chk_en, input logic [31:0] chk_val);
        IOBUS_WR   = wr;
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        TX_READY   = rdy;
        @(negedge CLK);
        checkOutput(chk_en, chk_val);
        @(posedge CLK);
        if (!RESET_N) model_reset();
        else model_edge(wr, a, d, rdy, SWITCHES);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        addr_list[0] = A_SW;     addr_list[1] = A_LED;
        addr_list[2] = A_TCNT;   addr_list[3] = A_TCMP;
        addr_list[4] = A_TCTRL;  addr_list[5] = A_TXD;
        addr_list[6] = A_TXSTAT; addr_list[7] = BASE + 32'h10;
        addr_list[8] = BASE + 32'h04; addr_list[9] = 32'h0100_0020;

        RESET_N    = 1'b0;
        SWITCHES   = 16'hA5C3;
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = A_SW;
        IOBUS_OUT  = 32'h0;
        TX_READY   = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        applyStimulus(0, A_SW, 0, 0, 0, 0);
        applyStimulus(0, A_SW, 0, 0, 0, 0);

        // Release reset between edges, switches appear after two syncing edges
        RESET_N = 1'b1;
        applyStimulus(0, A_SW, 0, 0, 1, 32'h0);
        applyStimulus(0, A_SW, 0, 0, 1, 32'h0);
        applyStimulus(0, A_SW, 0, 0, 1, 32'h0000_A5C3);

        // LED register and unmapped decode
        applyStimulus(1, A_LED, 32'h1234_FFFF, 0, 0, 0);
        applyStimulus(0, A_LED, 0, 0, 1, 32'h0000_FFFF);
        applyStimulus(0, BASE + 32'h10, 0, 0, 1, 32'h0);
        applyStimulus(1, BASE + 32'h10, 32'hDEAD_BEEF, 0, 0, 0);
        applyStimulus(0, A_LED, 0, 0, 1, 32'h0000_FFFF);
        applyStimulus(1, 32'h0100_0020, 32'h0000_0001, 0, 0, 0);
        applyStimulus(0, A_LED, 0, 0, 1, 32'h0000_FFFF);

        // Timer wrap and compare
        applyStimulus(1, A_TCNT, 32'hFFFF_FFFE, 0, 0, 0);
        applyStimulus(1, A_TCMP, 32'h3, 0, 0, 0);
        applyStimulus(1, A_TCTRL, 32'h1, 0, 0, 0);
        applyStimulus(0, A_TCNT, 0, 0, 1, 32'hFFFF_FFFE);
        applyStimulus(0, A_TCNT, 0, 0, 1, 32'hFFFF_FFFF);
        applyStimulus(0, A_TCNT, 0, 0, 1, 32'h0);
        applyStimulus(0, A_TCNT, 0, 0, 1, 32'h1);
        applyStimulus(0, A_TCNT, 0, 0, 1, 32'h2);
        applyStimulus(0, A_TCNT, 0, 0, 1, 32'h3);
        applyStimulus(0, A_TCTRL, 0, 0, 1, 32'h3);
        applyStimulus(1, A_TCTRL, 32'h3, 0, 0, 0);
        applyStimulus(0, A_TCTRL, 0, 0, 1, 32'h1);

        // Clear coinciding with a fresh match: the match must win
        applyStimulus(1, A_TCMP, m_tcnt + 32'h2, 0, 0, 0);
        applyStimulus(0, A_TCNT, 0, 0, 0, 0);
        applyStimulus(1, A_TCTRL, 32'h3, 0, 0, 0);
        applyStimulus(0, A_TCTRL, 0, 0, 1, 32'h3);

        // TCMP = 0 never matches even as TCNT passes through 0
        applyStimulus(1, A_TCMP, 32'h0, 0, 0, 0);
        applyStimulus(1, A_TCTRL, 32'h3, 0, 0, 0);
        applyStimulus(1, A_TCNT, 32'h0, 0, 0, 0);
        applyStimulus(0, A_TCNT, 0, 0, 1, 32'h0);
        applyStimulus(0, A_TCTRL, 0, 0, 1, 32'h1);
        applyStimulus(1, A_TCTRL, 32'h0, 0, 0, 0);

        // Overfill with TX_READY low, then drain
        for (int i = 0; i < 9; i++) applyStimulus(1, A_TXD, 32'h11 + i, 0, 0, 0);
        applyStimulus(0, A_TXD, 0, 0, 1, 32'h0);
        applyStimulus(0, A_TXSTAT, 0, 0, 1, 32'h0008_0006);
        for (int i = 0; i < 8; i++) applyStimulus(0, A_TXSTAT, 0, 1, 0, 0);
        applyStimulus(0, A_TXSTAT, 0, 1, 1, 32'h0000_0005);
        applyStimulus(1, A_TXSTAT, 32'h4, 0, 0, 0);
        applyStimulus(0, A_TXSTAT, 0, 0, 1, 32'h0000_0001);

        // Push and pop together while full
        for (int i = 0; i < 8; i++) applyStimulus(1, A_TXD, 32'h21 + i, 0, 0, 0);
        applyStimulus(1, A_TXD, 32'hAA, 1, 0, 0);
        applyStimulus(0, A_TXSTAT, 0, 0, 1, 32'h0008_0002);
        for (int i = 0; i < 9; i++) applyStimulus(0, A_TXSTAT, 0, 1, 0, 0);
        applyStimulus(0, A_TXSTAT, 0, 0, 1, 32'h0000_0001);

        // Reset asserted between edges with data in flight
        for (int i = 0; i < 3; i++) applyStimulus(1, A_TXD, 32'h31 + i, 0, 0, 0);
        RESET_N = 1'b0;
        #1;
        check32("rst_tx_valid", {31'h0, TX_VALID}, 32'h0);
        check32("rst_leds", {16'h0, LEDS}, 32'h0);
        check32("rst_tx_data", {24'h0, TX_DATA}, 32'h0);
        model_reset();
        applyStimulus(0, A_TXSTAT, 0, 0, 1, 32'h0000_0001);
        RESET_N = 1'b1;
        applyStimulus(0, A_TXSTAT, 0, 0, 1, 32'h0000_0001);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic        w;
            logic        r;
            a = addr_list[$urandom_range(0, 9)];
            if ($urandom_range(0, 2) == 0) a = A_TXD;
            w = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 3) == 0);
            d = $urandom;
            if (a == A_TCMP && $urandom_range(0, 1) == 1) d = m_tcnt + $urandom_range(1, 6);
            if (a == A_TCTRL && $urandom_range(0, 1) == 1) d = {30'h0, 1'b0, 1'b1};
            if (a == A_TCNT && $urandom_range(0, 1) == 1) d = m_tcmp - $urandom_range(0, 4);
            SWITCHES = 16'($urandom);
            applyStimulus(w, a, d, r, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/otter_iobus_responder.md
Name: otter_iobus_responder

Overview:
Memory-mapped I/O peripheral that sits on the OTTER_MCU IOBUS as the responding end. It decodes IOBUS_ADDR / IOBUS_WR / IOBUS_OUT from the MCU and returns read data on IOBUS_IN. It provides a switch input port, an LED output register, a programmable 32-bit timer with sticky compare interrupt, and an 8-bit transmit FIFO with a valid/ready output stream. It is instantiated beside OTTER_MCU in the top level and in system-level benches.

Parameters:
BASE_ADDR, 32'h1100_0000, base of the register window; registers sit at fixed byte offsets from it.
FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, 2..64.
SW_WIDTH, 16, switch input width, zero-extended on read.
LED_WIDTH, 16, LED register width.

Ports:
CLK  in  1  system clock; all state updates on the rising edge.
RESET_N  in  1  asynchronous, active-low reset.
IOBUS_ADDR  in  32  MCU I/O address.
IOBUS_OUT  in  32  MCU write data.
IOBUS_WR  in  1  MCU write strobe, one cycle per write.
IOBUS_IN  out  32  read data to the MCU.
SWITCHES  in  SW_WIDTH  asynchronous board switches.
LEDS  out  LED_WIDTH  LED register.
INTR  out  1  timer interrupt level to the MCU.
TX_DATA  out  8  FIFO head byte.
TX_VALID  out  1  FIFO not empty.
TX_READY  in  1  downstream accepts TX_DATA this cycle.

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0x00 SW: read-only; 2-flop synchronised SWITCHES.
  - +0x20 LED: read/write.
  - +0x40 TCNT: read/write.
  - +0x44 TCMP: read/write.
  - +0x48 TCTRL:
    - bit0 EN: read/write.
    - bit1 PEND: read; write 1 clears.
  - +0x60 TXD: write pushes IOBUS_OUT[7:0]; reads 0.
  - +0x64 TXSTAT: read {count[23:16], OVF[2], FULL[1], EMPTY[0]}; writing bit2=1 clears OVF.
- Decode is a full 32-bit compare. Unmapped reads return 0. Unmapped writes are ignored.
- Writes take effect on the rising edge where IOBUS_WR=1.
- IOBUS_IN is combinational from IOBUS_ADDR and registered state. There is zero read latency and reads have no side effects.
- Reset (RESET_N=0, asynchronous): all registers clear to 0.
  - LEDS=0, INTR=0, TX_VALID=0, TX_DATA=0.
  - FIFO is empty, OVF=0.
  - Synchroniser flops clear to 0, so SW reads 0 for 2 cycles after release.
  - Reset mid-transfer discards FIFO contents.
- Timer:
  - When EN=1, TCNT increments every cycle and wraps 0xFFFF_FFFF→0.
  - A write to TCNT loads IOBUS_OUT and has priority over the increment that cycle.
  - When EN=1, TCMP≠0 and TCNT==TCMP, PEND sets on the next edge. PEND is sticky.
  - INTR = PEND.
  - A W1C write to TCTRL in the same cycle as a new match: set wins, PEND stays 1.
  - TCMP=0 never matches.
- TX FIFO:
  - Circular buffer with a count of log2(FIFO_DEPTH)+1 bits.
  - TX_VALID = !EMPTY. TX_DATA = head entry (0 when empty).
  - Pop happens on an edge where TX_VALID && TX_READY.
  - Push when not full: accepted.
  - Push when full with no pop the same cycle: dropped, OVF sets sticky, contents unchanged.
  - Push and pop the same cycle when full: both occur, count unchanged, no OVF.
  - Push into an empty FIFO: TX_VALID rises on the next cycle. There is no bypass.
  - Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset then release; SWITCHES=16'hA5C3; read +0x00 on cycles 1, 2, 3 → 0, 0, 0x0000_A5C3. LEDS=0, INTR=0, TX_VALID=0 throughout.
- Write 0x1234_FFFF to +0x20 → LEDS=16'hFFFF, readback 0x0000_FFFF. Read 0x1100_0010 → 0. Write 0x1100_0010 → no state change.
- Write TCNT=0xFFFF_FFFE, TCMP=3, TCTRL=1 → TCNT reads 0xFFFF_FFFF, 0, 1, 2, 3. INTR=1 on the edge after TCNT=3. Write TCTRL=0x3 → INTR=0, EN stays 1.
- TX_READY=0; push 0x11..0x19 (9 writes) → FULL=1, count=8, OVF=1, TX_DATA=0x11. Raise TX_READY → bytes 0x11..0x18 drain in order, then EMPTY=1.
- FIFO full, TX_READY=1, push 0xAA in the same cycle → count stays 8, OVF stays 0, 0xAA appears last.
- Push 3 bytes, assert RESET_N=0 between edges → TX_VALID drops immediately, count=0, LEDS=0.
